// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_arb_pkg
// Brief   : Shared types and helpers for the block-RAM arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int BLK_BYTES = 16;

   // Index width that never collapses to zero for tiny channel counts.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_block_arbiter_rr_picker.sv
//------------------------------------------------------------------------------
// Module  : rr_picker
// Brief   : Combinational first-valid picker starting at ptr (mode=1: from 0).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
   parameter int NUM_CH = 3,
   parameter int PW     = 2
) (
   input  logic [NUM_CH-1:0] valid,
   input  logic [PW-1:0]     ptr,
   input  logic              mode,
   output logic              found,
   output logic [PW-1:0]     idx
);

   logic [PW-1:0]     w_base;
   logic [NUM_CH-1:0] w_rot;
   logic [PW:0]       w_sum;

   // Doubling the vector lets a plain shift act as a rotate for any NUM_CH.
   always_comb begin
      w_base = mode ? '0 : ptr;
      w_rot  = NUM_CH'({valid, valid} >> w_base);
      found  = 1'b0;
      idx    = '0;
      w_sum  = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            found = 1'b1;
            w_sum = {1'b0, w_base} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_CH)) begin
               w_sum = w_sum - (PW+1)'(NUM_CH);
            end
            idx = w_sum[PW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_block_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mem_block_arbiter
// Brief   : N-channel arbiter sharing one block-wide slow-RAM port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_block_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH    = 3,
   parameter int ADDR_W    = 32,
   parameter int BLK_W     = 128,
   parameter int PRIO_MODE = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic [NUM_CH-1:0]          req_valid,
   input  logic [NUM_CH-1:0]          req_we,
   input  logic [NUM_CH-1:0]          req_lock,
   input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CH*BLK_W-1:0]    req_din,
   output logic [BLK_W-1:0]           req_dout,
   output logic [NUM_CH-1:0]          req_done,
   output logic [NUM_CH-1:0]          req_err,
   output logic [NUM_CH-1:0]          req_hold,
   output logic                       ram_en,
   output logic                       ram_we,
   output logic [ADDR_W-1:0]          ram_addr,
   output logic [BLK_W-1:0]           ram_din,
   input  logic [BLK_W-1:0]           ram_dout,
   input  logic                       ram_ack,
   output logic [clog2_min1(NUM_CH)-1:0] grant_id
);

   localparam int GW = clog2_min1(NUM_CH);
   localparam int CW = clog2_min1(TIMEOUT + 1);
   localparam logic [CW-1:0] C_CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t          r_state;
   logic [GW-1:0]   r_ptr;
   logic            r_lock_vld;
   logic [GW-1:0]   r_lock_id;
   logic [CW-1:0]   r_cnt;

   logic            w_pick_found;
   logic [GW-1:0]   w_pick_idx;
   logic            w_lock_hit;
   logic            w_win;
   logic [GW-1:0]   w_win_idx;
   logic [GW-1:0]   w_next_ptr;
   logic            w_timeout;

   rr_picker #(
      .NUM_CH (NUM_CH),
      .PW     (GW)
   ) u_picker (
      .valid  (req_valid),
      .ptr    (r_ptr),
      .mode   (PRIO_MODE != 0),
      .found  (w_pick_found),
      .idx    (w_pick_idx)
   );

   assign w_lock_hit = r_lock_vld & req_valid[r_lock_id];
   assign w_win      = w_lock_hit | w_pick_found;
   assign w_win_idx  = w_lock_hit ? r_lock_id : w_pick_idx;
   assign w_next_ptr = (grant_id == GW'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
   assign w_timeout  = (TIMEOUT != 0) && (r_cnt == C_CNT_LAST);
   assign req_hold   = req_valid & ~req_done & ~req_err;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_lock_vld <= 1'b0;
         r_lock_id  <= '0;
         r_cnt      <= '0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         req_dout   <= '0;
         req_done   <= '0;
         req_err    <= '0;
         grant_id   <= '0;
      end else begin
         req_done <= '0;
         req_err  <= '0;
         case (r_state)
            IDLE: begin
               // An owner that stops requesting gives the bus back.
               if (r_lock_vld && !req_valid[r_lock_id]) begin
                  r_lock_vld <= 1'b0;
               end
               if (w_win) begin
                  ram_en   <= 1'b1;
                  ram_we   <= req_we[w_win_idx];
                  ram_addr <= req_addr[w_win_idx*ADDR_W +: ADDR_W];
                  ram_din  <= req_din[w_win_idx*BLK_W +: BLK_W];
                  grant_id <= w_win_idx;
                  r_cnt    <= '0;
                  r_state  <= BUSY;
               end
            end
            BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (ram_ack) begin
                  ram_en <= 1'b0;
                  if (!ram_we) begin
                     req_dout <= ram_dout;
                  end
                  req_done[grant_id] <= 1'b1;
                  r_ptr      <= w_next_ptr;
                  r_lock_vld <= req_lock[grant_id];
                  r_lock_id  <= grant_id;
                  r_cnt      <= '0;
                  r_state    <= IDLE;
               end else if (w_timeout) begin
                  ram_en            <= 1'b0;
                  req_err[grant_id] <= 1'b1;
                  r_ptr             <= w_next_ptr;
                  r_lock_vld        <= 1'b0;
                  r_cnt             <= '0;
                  r_state           <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_block_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_block_arbiter
// Brief   : Scoreboard bench: random traffic on a round-robin/timeout arbiter,
//           directed fixed-priority and no-timeout checks on a second instance.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_block_arbiter;

   localparam int NCH = 3;
   localparam int AW  = 32;
   localparam int BW  = 128;
   localparam int TMO = 8;

   logic CLK = 1'b0;
   logic RESET_N;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   logic [NCH-1:0]    req_valid, req_we, req_lock, req_done, req_err, req_hold;
   logic [NCH*AW-1:0] req_addr;
   logic [NCH*BW-1:0] req_din;
   logic [BW-1:0]     req_dout, ram_din, ram_dout;
   logic              ram_en, ram_we, ram_ack;
   logic [AW-1:0]     ram_addr;
   logic [1:0]        grant_id;

   logic [NCH-1:0]    req_valid_b, req_we_b, req_lock_b, req_done_b, req_err_b, req_hold_b;
   logic [NCH*AW-1:0] req_addr_b;
   logic [NCH*BW-1:0] req_din_b;
   logic [BW-1:0]     req_dout_b, ram_din_b, ram_dout_b;
   logic              ram_en_b, ram_we_b, ram_ack_b;
   logic [AW-1:0]     ram_addr_b;
   logic [1:0]        grant_id_b;

   mem_block_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .BLK_W(BW), .PRIO_MODE(0), .TIMEOUT(TMO)) u_dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_din(req_din), .req_dout(req_dout),
      .req_done(req_done), .req_err(req_err), .req_hold(req_hold),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .ram_ack(ram_ack), .grant_id(grant_id)
   );

   mem_block_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .BLK_W(BW), .PRIO_MODE(1), .TIMEOUT(0)) u_dut_fp (
      .CLK(CLK), .RESET_N(RESET_N),
      .req_valid(req_valid_b), .req_we(req_we_b), .req_lock(req_lock_b),
      .req_addr(req_addr_b), .req_din(req_din_b), .req_dout(req_dout_b),
      .req_done(req_done_b), .req_err(req_err_b), .req_hold(req_hold_b),
      .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b),
      .ram_dout(ram_dout_b), .ram_ack(ram_ack_b), .grant_id(grant_id_b)
   );

   typedef struct {
      int          ch;
      bit          we;
      logic [AW-1:0] addr;
      logic [BW-1:0] din;
      int          at;
   } issue_t;

   typedef struct {
      int          ch;
      bit          err;
      logic [BW-1:0] dout;
      int          at;
   } resp_t;

   issue_t exp_issue[$];
   resp_t  exp_resp[$];
   bit     mon_en = 1'b0;
   int     n_checks = 0;
   int     n_fail = 0;

   // Reference model: arbiter seen as "idle or serving one channel".
   bit            m_busy, m_lock_vld, m_issue_we;
   int            m_grant, m_ptr, m_lock_id, m_en_cyc, m_delay, m_fin;
   logic [BW-1:0] m_dout;
   int            delay_opts[6] = '{0, 1, 2, 3, 7, 99};

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [BW-1:0] rnd_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic new_req(input int ch);
      req_valid[ch]            = 1'b1;
      req_we[ch]               = 1'($urandom_range(0, 1));
      req_lock[ch]             = ($urandom_range(0, 3) == 0);
      req_addr[ch*AW +: AW]    = $urandom & 32'hFFFF_FFF0;
      req_din[ch*BW +: BW]     = rnd_blk();
   endtask

   task automatic finish_txn(input bit err);
      resp_t r;
      if (!err && !m_issue_we) m_dout = ram_dout;
      r.ch = m_grant; r.err = err; r.dout = m_dout; r.at = cyc + 1;
      exp_resp.push_back(r);
      m_busy     = 1'b0;
      m_ptr      = (m_grant + 1) % NCH;
      m_lock_vld = !err && req_lock[m_grant];
      m_lock_id  = m_grant;
      m_fin      = m_grant;
   endtask

   // One negedge step: inputs set here are sampled at the next posedge.
   task automatic step(input bit allow_new);
      int     w;
      issue_t it;
      if (m_fin >= 0) req_valid[m_fin] = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (allow_new && !req_valid[c] &&
             $urandom_range(0, 3) < ((c == m_fin && req_lock[c]) ? 3 : 1)) new_req(c);
      end
      m_fin   = -1;
      ram_ack = 1'b0;
      if (m_busy) begin
         m_en_cyc++;
         if (m_delay == 0) begin
            ram_ack  = 1'b1;
            ram_dout = rnd_blk();
            finish_txn(1'b0);
         end else begin
            m_delay--;
            if (m_en_cyc == TMO) finish_txn(1'b1);
         end
      end else begin
         if ($urandom_range(0, 7) == 0) begin
            ram_ack  = 1'b1;
            ram_dout = rnd_blk();
         end
         if (m_lock_vld && !req_valid[m_lock_id]) m_lock_vld = 1'b0;
         w = -1;
         if (m_lock_vld) w = m_lock_id;
         else begin
            for (int k = 0; k < NCH; k++)
               if (w < 0 && req_valid[(m_ptr + k) % NCH]) w = (m_ptr + k) % NCH;
         end
         if (w >= 0) begin
            it.ch = w; it.we = req_we[w]; it.addr = req_addr[w*AW +: AW];
            it.din = req_din[w*BW +: BW]; it.at = cyc + 1;
            exp_issue.push_back(it);
            m_busy = 1'b1; m_grant = w; m_en_cyc = 0; m_issue_we = req_we[w];
            m_delay = delay_opts[$urandom_range(0, 5)];
         end
      end
   endtask

   task automatic wait_en(input bit use_b, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (use_b ? ram_en_b : ram_en) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Monitor: compares DUT activity with the scoreboard queues.
   initial begin : monitor
      issue_t it;
      resp_t  rs;
      logic   prev_en;
      prev_en = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (mon_en) begin
            chk("hold", req_hold, req_valid & ~req_done & ~req_err);
            if (ram_en && !prev_en) begin
               if (exp_issue.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL issue: unexpected ram_en for ch %0d, expected none", grant_id);
               end else begin
                  it = exp_issue.pop_front();
                  chk("issue_cycle", cyc, it.at);
                  chk("grant_id", grant_id, it.ch);
                  chk("ram_addr", ram_addr, it.addr);
                  chk("ram_we", ram_we, it.we);
                  chk("ram_din", ram_din, it.din);
               end
            end
            if (|req_done || |req_err) begin
               if (exp_resp.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL resp: unexpected done=%b err=%b, expected none", req_done, req_err);
               end else begin
                  rs = exp_resp.pop_front();
                  chk("resp_cycle", cyc, rs.at);
                  chk("req_done", req_done, rs.err ? 0 : (1 << rs.ch));
                  chk("req_err", req_err, rs.err ? (1 << rs.ch) : 0);
                  chk("req_dout", req_dout, rs.dout);
               end
            end
         end
         prev_en = ram_en;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit ok;
      bit stuck_ok;
      RESET_N = 1'b0;
      req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_din = '0;
      ram_dout = '0; ram_ack = 1'b0;
      req_valid_b = '0; req_we_b = '0; req_lock_b = '0; req_addr_b = '0; req_din_b = '0;
      ram_dout_b = '0; ram_ack_b = 1'b0;
      m_busy = 0; m_lock_vld = 0; m_issue_we = 0; m_grant = 0; m_ptr = 0;
      m_lock_id = 0; m_en_cyc = 0; m_delay = 0; m_fin = -1; m_dout = '0;

      repeat (3) @(negedge CLK);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_req_dout", req_dout, 0);
      chk("rst_req_done", req_done, 0);
      chk("rst_req_err", req_err, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_b_ram_en", ram_en_b, 0);
      chk("rst_b_grant_id", grant_id_b, 0);
      RESET_N = 1'b1;
      mon_en  = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         step(1'b1);
         @(negedge CLK);
      end
      for (int i = 0; i < 300 && (m_busy || m_fin >= 0 || |req_valid); i++) begin
         step(1'b0);
         @(negedge CLK);
      end
      chk("drain_idle", {m_busy, |req_valid}, 0);
      repeat (3) begin
         step(1'b0);
         @(negedge CLK);
      end
      chk("issue_q_empty", exp_issue.size(), 0);
      chk("resp_q_empty", exp_resp.size(), 0);
      mon_en  = 1'b0;
      ram_ack = 1'b0;

      // Asynchronous reset in the middle of a transaction.
      new_req(1);
      wait_en(1'b0, ok);
      chk("mid_wait_en", ok, 1);
      chk("mid_pre_grant", grant_id, 1);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_ram_en", ram_en, 0);
      chk("mid_rst_done", req_done, 0);
      chk("mid_rst_grant", grant_id, 0);
      chk("mid_rst_addr", ram_addr, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      new_req(0);
      new_req(2);
      wait_en(1'b0, ok);
      chk("post_rst_wait_en", ok, 1);
      chk("post_rst_grant", grant_id, 0);
      ram_ack = 1'b1; ram_dout = rnd_blk();
      @(negedge CLK);
      ram_ack = 1'b0;
      chk("post_rst_done", req_done, 3'b001);
      req_valid = '0;

      // Fixed priority: ch0 keeps re-requesting and starves ch2.
      req_valid_b = 3'b101;
      req_addr_b[0 +: AW]    = $urandom & 32'hFFFF_FFF0;
      req_addr_b[2*AW +: AW] = 32'h0000_2000;
      for (int t = 0; t < 5; t++) begin
         wait_en(1'b1, ok);
         chk("fp_wait_en", ok, 1);
         chk("fp_grant", grant_id_b, 0);
         chk("fp_addr", ram_addr_b, req_addr_b[0 +: AW]);
         ram_ack_b = 1'b1; ram_dout_b = rnd_blk();
         @(negedge CLK);
         ram_ack_b = 1'b0;
         chk("fp_done", req_done_b, 3'b001);
         chk("fp_dout", req_dout_b, ram_dout_b);
         if (t == 4) req_valid_b[0] = 1'b0;
         else req_addr_b[0 +: AW] = $urandom & 32'hFFFF_FFF0;
      end
      wait_en(1'b1, ok);
      chk("fp_ch2_wait_en", ok, 1);
      chk("fp_ch2_grant", grant_id_b, 2);
      chk("fp_ch2_addr", ram_addr_b, 32'h0000_2000);
      ram_ack_b = 1'b1;
      @(negedge CLK);
      ram_ack_b = 1'b0;
      chk("fp_ch2_done", req_done_b, 3'b100);
      req_valid_b = '0;

      // TIMEOUT=0: the request must wait for an ack indefinitely.
      req_valid_b = 3'b010;
      req_addr_b[AW +: AW] = 32'h0000_0040;
      wait_en(1'b1, ok);
      chk("nto_wait_en", ok, 1);
      chk("nto_grant", grant_id_b, 1);
      stuck_ok = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         if (!ram_en_b || |req_err_b || |req_done_b) stuck_ok = 1'b0;
      end
      chk("nto_still_waiting", stuck_ok, 1);
      ram_ack_b = 1'b1;
      @(negedge CLK);
      ram_ack_b = 1'b0;
      chk("nto_done", req_done_b, 3'b010);
      req_valid_b = '0;
      repeat (2) @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
